// File: rtl/serial_to_parallel.sv
// serial_to_parallel: LSB-first deserializer with word sync,
// 2-entry output FIFO, framing-error pulse and sticky overflow.
module serial_to_parallel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             sync,
  input  logic             out_ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             frame_err,
  output logic             overflow,
  output logic             locked
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    HUNT,
    SHIFT
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;
  logic [1:0]       occ;

  logic             mid_sync;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] word;

  // Word completion, misaligned sync and pop decode
  always_comb begin
    mid_sync = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    word     = {din, shift[WIDTH-2:0]};
    if (state == SHIFT) begin
      mid_sync = sync && (cnt != '0);
      push     = !mid_sync && (cnt == LAST);
    end
    pop = (occ != 2'd0) && out_ready;
  end

  // Alignment FSM and bit assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      cnt       <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      unique case (state)
        HUNT: begin
          if (sync) begin
            shift[0] <= din;
            cnt      <= CW'(1);
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (mid_sync) begin
            frame_err <= 1'b1;
            shift[0]  <= din;
            cnt       <= CW'(1);
          end else if (cnt == LAST) begin
            cnt <= '0;
          end else begin
            shift[cnt] <= din;
            cnt        <= cnt + CW'(1);
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  // Output FIFO: q0 is head and keeps the last popped word when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0       <= '0;
      q1       <= '0;
      occ      <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (push && pop) begin
        if (occ == 2'd2) begin
          q0 <= q1;
          q1 <= word;
        end else begin
          q0 <= word;
        end
      end else if (push) begin
        if (occ == 2'd0) begin
          q0  <= word;
          occ <= 2'd1;
        end else if (occ == 2'd1) begin
          q1  <= word;
          occ <= 2'd2;
        end
      end else if (pop) begin
        if (occ == 2'd2) begin
          q0 <= q1;
        end
        occ <= occ - 2'd1;
      end
      if (push && !pop && (occ == 2'd2)) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign dout       = q0;
  assign dout_valid = (occ != 2'd0);
  assign locked     = (state == SHIFT);

endmodule

// File: tb/tb_serial_to_parallel.sv
// tb_serial_to_parallel: directed vectors for the deserializer,
// with a pop log to check output order and spacing.
module tb_serial_to_parallel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       sync;
  logic       out_ready;
  logic       ovf_clr;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_err;
  logic       overflow;
  logic       locked;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ferr_cnt = 0;
  bit valid_seen = 0;
  logic [7:0] popq[$];
  int         popc[$];

  serial_to_parallel #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .sync(sync),
    .out_ready(out_ready),
    .ovf_clr(ovf_clr),
    .dout(dout),
    .dout_valid(dout_valid),
    .frame_err(frame_err),
    .overflow(overflow),
    .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_bit(input logic b, input logic s);
    @(negedge clk);
    din  = b;
    sync = s;
    if (dout_valid && out_ready) begin
      popq.push_back(dout);
      popc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (frame_err) ferr_cnt++;
    if (dout_valid) valid_seen = 1;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n,
                           input logic s);
    for (int i = 0; i < n; i++) send_bit(v[i], s && (i == 0));
  endtask

  task automatic send_word(input logic [7:0] v, input logic s);
    send_bits(v, 8, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    din       = 1'b0;
    sync      = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    popq.delete();
    popc.delete();
    ferr_cnt   = 0;
    valid_seen = 0;
  endtask

  initial begin
    do_reset();
    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);

    // single word 0xA5
    send_bit(1'b1, 1'b1);
    check("a5_locked", locked, 1);
    send_bits(8'hA5 >> 1, 7, 1'b0);
    check("a5_valid", dout_valid, 1);
    check("a5_dout", dout, 8'hA5);
    send_bit(1'b0, 1'b0);
    check("a5_valid_1cyc", dout_valid, 0);
    check("a5_hold", dout, 8'hA5);
    check("a5_ferr", ferr_cnt, 0);
    check("a5_ovf", overflow, 0);

    // back-to-back stream
    do_reset();
    send_word(8'h3C, 1'b1);
    send_word(8'hFF, 1'b0);
    send_word(8'h00, 1'b0);
    send_bit(1'b0, 1'b0);
    check("bb_count", popq.size(), 3);
    if (popq.size() == 3) begin
      check("bb_w0", popq[0], 8'h3C);
      check("bb_w1", popq[1], 8'hFF);
      check("bb_w2", popq[2], 8'h00);
      check("bb_gap01", popc[1] - popc[0], 8);
      check("bb_gap12", popc[2] - popc[1], 8);
    end
    check("bb_ferr", ferr_cnt, 0);

    // resync mid-word
    do_reset();
    send_bits(8'h12, 4, 1'b1);
    send_bit(1'b1, 1'b1);
    check("fe_pulse", frame_err, 1);
    send_bits(8'h81 >> 1, 7, 1'b0);
    check("fe_once", ferr_cnt, 1);
    check("fe_dout", dout, 8'h81);
    check("fe_valid", dout_valid, 1);
    send_bit(1'b0, 1'b0);
    check("fe_popn", popq.size(), 1);
    if (popq.size() == 1) check("fe_pop", popq[0], 8'h81);

    // overflow with stalled consumer
    do_reset();
    out_ready = 1'b0;
    send_word(8'h01, 1'b1);
    send_word(8'h02, 1'b0);
    check("of_head", dout, 8'h01);
    check("of_noovf", overflow, 0);
    send_word(8'h03, 1'b0);
    check("of_ovf", overflow, 1);
    out_ready = 1'b1;
    repeat (3) send_bit(1'b0, 1'b0);
    check("of_popn", popq.size(), 2);
    if (popq.size() == 2) begin
      check("of_p0", popq[0], 8'h01);
      check("of_p1", popq[1], 8'h02);
    end
    check("of_empty", dout_valid, 0);
    check("of_sticky", overflow, 1);
    ovf_clr = 1'b1;
    send_bit(1'b0, 1'b0);
    ovf_clr = 1'b0;
    check("of_clr", overflow, 0);

    // full buffer, pop on the completing cycle
    do_reset();
    out_ready = 1'b0;
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b0);
    send_bits(8'h33, 7, 1'b0);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    check("fp_noovf", overflow, 0);
    check("fp_head", dout, 8'h22);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    check("fp_popn", popq.size(), 3);
    if (popq.size() == 3) begin
      check("fp_p0", popq[0], 8'h11);
      check("fp_p1", popq[1], 8'h22);
      check("fp_p2", popq[2], 8'h33);
    end

    // reset mid-word
    do_reset();
    out_ready = 1'b0;
    send_word(8'h5A, 1'b1);
    send_bits(8'h0F, 5, 1'b0);
    check("mr_pre_valid", dout_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_dout", dout, 0);
    check("mr_valid", dout_valid, 0);
    check("mr_locked", locked, 0);
    check("mr_ferr", frame_err, 0);
    check("mr_ovf", overflow, 0);
    @(negedge clk);
    rst_n      = 1'b1;
    out_ready  = 1'b1;
    valid_seen = 0;
    for (int i = 0; i < 20; i++) send_bit(i[0], 1'b0);
    check("mr_nosync_valid", valid_seen, 0);
    check("mr_nosync_lock", locked, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
